// File: rtl/adder_pkg.sv
// Shared definitions for the serial slice adder: FSM encoding, slice width and
// the slice-counter width helper.
package adder_pkg;

    localparam int unsigned SLICE_W = 4;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StRun  = 2'd1;
    localparam state_t StDone = 2'd2;

    // A single-slice configuration still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned slices);
        if (slices <= 1) begin
            return 1;
        end
        return $clog2(slices);
    endfunction

endpackage

// File: rtl/ripple_adder.sv
// Combinational 4-bit ripple-carry adder; the single datapath slice reused
// every cycle by serial_slice_adder.
module ripple_adder (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       ci,
    output logic [3:0] SUM,
    output logic       co
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        SUM      = '0;
        carry[0] = ci;
        for (int i = 0; i < 4; i++) begin
            SUM[i]       = A[i] ^ B[i] ^ carry[i];
            carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
        end
        co = carry[4];
    end

endmodule

// File: rtl/serial_slice_adder.sv
// Multi-cycle n-bit adder: walks the operands w bits per cycle through one
// ripple_adder, chaining the carry through a register.
module serial_slice_adder
    import adder_pkg::*;
#(
    parameter int unsigned n = 24,
    parameter int unsigned w = SLICE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] A,
    input  logic [n-1:0] B,
    input  logic         ci,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] SUM,
    output logic         co,
    output logic         busy
);

    localparam int unsigned NumSlices = n / w;
    localparam int unsigned CntW      = cnt_width(NumSlices);
    localparam logic [CntW-1:0] LastCnt = CntW'(NumSlices - 1);

    generate
        if ((w != SLICE_W) || (n < w) || ((n % w) != 0)) begin : g_bad_params
            $error("serial_slice_adder: n must be a non-zero multiple of w, and w must be 4");
        end
    endgenerate

    state_t            state_q, state_d;
    logic [n-1:0]      a_sh_q, a_sh_d;
    logic [n-1:0]      b_sh_q, b_sh_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [n-1:0]      sum_q, sum_d;
    logic              co_q, co_d;

    logic [SLICE_W-1:0]   slice_a, slice_b, slice_sum;
    logic                 slice_co;
    logic [n+SLICE_W-1:0] sum_cat;

    assign slice_a = a_sh_q[SLICE_W-1:0];
    assign slice_b = b_sh_q[SLICE_W-1:0];

    ripple_adder u_slice (
        .A   (slice_a),
        .B   (slice_b),
        .ci  (carry_q),
        .SUM (slice_sum),
        .co  (slice_co)
    );

    // New slice enters at the MSB end; the concat/shift form also covers n == w.
    assign sum_cat = {slice_sum, sum_q} >> w;

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        co_d    = co_q;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = A;
                    b_sh_d  = B;
                    carry_d = ci;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = sum_cat[n-1:0];
                a_sh_d  = a_sh_q >> w;
                b_sh_d  = b_sh_q >> w;
                carry_d = slice_co;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    co_d    = slice_co;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign busy      = (state_q == StRun);
    assign out_valid = (state_q == StDone);
    assign SUM       = sum_q;
    assign co        = co_q;

endmodule

// File: doc/serial_slice_adder.md
Name: serial_slice_adder

Overview:
- Multi-cycle, carry-chained adder for wide operands.
- Each cycle it feeds one w-bit slice of A, B and a registered carry into a combinational 4-bit ripple_adder.
- It captures that slice's sum and carry-out, then advances to the next slice.
- Sits directly upstream/downstream of ripple_adder: supplies its operands and consumes its SUM/co. This gives an n-bit add with one 4-bit adder instead of n/4 chained instances.

Parameters:
- n, 24, operand/result width; must be a multiple of w, n >= w.
- w, 4, slice width; fixed to 4 (ripple_adder width). Elaboration error if n % w != 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept operands.
- A  input  n  operand A.
- B  input  n  operand B.
- ci  input  1  carry-in to the LSB slice.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- SUM  output  n  registered sum.
- co  output  1  registered carry-out of the MSB slice.
- busy  output  1  high in RUN.

Behaviour:
- State machine: IDLE, RUN, DONE.
- Reset (async, any state): state=IDLE, SUM=0, co=0, out_valid=0, busy=0, slice count=0, carry reg=0, operand shift regs=0. in_ready=1 while in IDLE, including during reset.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch A, B into shift regs; carry reg <= ci; count <= 0; go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle, ripple_adder gets A_sh[w-1:0], B_sh[w-1:0], carry reg.
  - Sum slice is shifted into SUM from the MSB end: SUM <= {slice_sum, SUM[n-1:w]}.
  - A_sh and B_sh shift right by w; carry reg <= slice co; count <= count+1.
  - At count == n/w-1: co <= slice co; go to DONE.
- DONE:
  - out_valid=1. SUM and co are held stable; in_ready=0; in_valid is ignored.
  - On out_ready: out_valid drops next cycle; go to IDLE.
- Latency: n/w cycles from the accept edge to out_valid=1 (6 for defaults).
- Throughput: one op per n/w+2 cycles. A new op may be accepted in the cycle after the out_ready handshake.
- Arithmetic: unsigned {co,SUM} = A + B + ci, exact. No overflow flag.
- Intermediate SUM bits are not valid outside DONE; the consumer samples only on out_valid.
- n == w: RUN lasts exactly 1 cycle.
- in_valid and out_ready held high continuously: strict alternation IDLE→RUN×(n/w)→DONE→IDLE with no lost or duplicated op.
- Reset mid-RUN or mid-DONE: the op is abandoned, no out_valid pulse, and the next op starts with a clean carry.
- Carry out of the last slice never leaks into the next op; the carry reg is reloaded from ci at accept.

Decomposition:
- Package adder_pkg holds:
  - state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - constant SLICE_W=4;
  - function for count width = $clog2(n/w) (min 1).
- One sub-module: ripple_adder (existing 4-bit slice), instantiated once as the datapath.
- FSM, count and shift regs stay in serial_slice_adder.

Test Plan:
1. rst=1 mid-stream, then released → out_valid=0, SUM=24'h000000, co=0, busy=0, in_ready=1 immediately.
2. A=24'h000001, B=24'h000001, ci=0 → out_valid rises exactly 6 cycles after accept; SUM=24'h000002, co=0.
3. A=24'hFFFFFF, B=24'h000000, ci=1 → carry crosses all 6 slices; SUM=24'h000000, co=1.
4. A=24'h123456, B=24'h654321, ci=0, out_ready=0 for 5 cycles while in_valid=1 → SUM=24'h777777 and co=0 stable; in_ready=0; second op not accepted until the handshake.
5. Back-to-back with in_valid=out_ready=1:
   - op1 A=24'h800000, B=24'h800000 → SUM=0, co=1;
   - op2 A=24'h00000F, B=24'h000001, ci=0 → SUM=24'h000010, co=0 (no stale carry).
6. rst pulse in RUN cycle 3 of op A=24'hFFFFFF, B=1 → no out_valid. Then op A=24'h000005, B=24'h000003 → SUM=24'h000008, co=0.
